// File: rtl/billiard_pkg.sv
// rtl/billiard_pkg.sv - shared types and table constants for the ball physics blocks
//
// Purpose : FSM state enum, velocity type, default table geometry and the
//           six pocket-centre coordinates derived from it.
// Ports   : none (package).
package billiard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CUSHION,
        ST_FRICTION,
        ST_OUTPUT,
        ST_SUNK
    } state_e;

    typedef logic signed [10:0] vel_t;

    localparam int TABLE_LEFT_DEF      = 32;
    localparam int TABLE_RIGHT_DEF     = 607;
    localparam int TABLE_TOP_DEF       = 32;
    localparam int TABLE_BOTTOM_DEF    = 447;
    localparam int BALL_SIZE_DEF       = 16;
    localparam int FRICTION_PERIOD_DEF = 4;
    localparam int FRICTION_STEP_DEF   = 1;
    localparam int POCKET_RADIUS_DEF   = 12;

    // Pocket centres: three columns (left, middle, right) on two rows.
    localparam int POCKET_X_LEFT   = TABLE_LEFT_DEF;
    localparam int POCKET_X_MID    = (TABLE_LEFT_DEF + TABLE_RIGHT_DEF) / 2;
    localparam int POCKET_X_RIGHT  = TABLE_RIGHT_DEF;
    localparam int POCKET_Y_TOP    = TABLE_TOP_DEF;
    localparam int POCKET_Y_BOTTOM = TABLE_BOTTOM_DEF;

    // Two's-complement negation with the one overflow case pinned to max.
    function automatic vel_t sat_neg(input vel_t v);
        if (v == 11'sh400) begin
            return 11'sh3FF;
        end
        return -v;
    endfunction

endpackage

// File: rtl/ball_pocket_detect.sv
// rtl/ball_pocket_detect.sv - combinational test of ball centre against the six pockets
//
// Purpose : flags when the ball centre is inside the square capture window
//           (inclusive, +-POCKET_RADIUS per axis) of any pocket.
// Ports   : centre_x, centre_y - 12-bit signed ball centre
//           hit                - 1 when any pocket captures the ball
module ball_pocket_detect
    import billiard_pkg::*;
#(
    parameter int POCKET_RADIUS = POCKET_RADIUS_DEF,
    parameter int X_LEFT        = POCKET_X_LEFT,
    parameter int X_MID         = POCKET_X_MID,
    parameter int X_RIGHT       = POCKET_X_RIGHT,
    parameter int Y_TOP         = POCKET_Y_TOP,
    parameter int Y_BOTTOM      = POCKET_Y_BOTTOM
) (
    input  logic signed [11:0] centre_x,
    input  logic signed [11:0] centre_y,
    output logic               hit
);

    localparam logic signed [12:0] RADIUS     = 13'(POCKET_RADIUS);
    localparam logic signed [12:0] NEG_RADIUS = -RADIUS;

    // 13-bit difference so a 12-bit centre minus a pocket coordinate cannot wrap.
    function automatic logic near(input logic signed [11:0] c, input int p);
        logic signed [12:0] d;
        d = {c[11], c} - 13'(p);
        return (d >= NEG_RADIUS) && (d <= RADIUS);
    endfunction

    logic near_xl, near_xm, near_xr, near_yt, near_yb;

    always_comb begin
        near_xl = near(centre_x, X_LEFT);
        near_xm = near(centre_x, X_MID);
        near_xr = near(centre_x, X_RIGHT);
        near_yt = near(centre_y, Y_TOP);
        near_yb = near(centre_y, Y_BOTTOM);
        hit     = (near_xl || near_xm || near_xr) && (near_yt || near_yb);
    end

endmodule

// File: rtl/ball_cushion_friction.sv
// rtl/ball_cushion_friction.sv - per-frame cushion reflection, friction decay and pocketing
//
// Purpose : once per startOfFrame, captures ball position/velocity, reflects
//           off cushions, applies friction every FRICTION_PERIOD frames and
//           publishes next-frame velocity three cycles later; sinks the ball
//           when it enters a pocket.
// Ports   : clk, reset (sync, active-high), startOfFrame (1-cycle pulse)
//           positionX/Y, velocityX/Y       - 11-bit signed ball state in
//           outVelocityX/Y                  - 11-bit signed next velocity
//           velocityValid                   - 1-cycle pulse on update
//           ballMoving                      - either out velocity nonzero
//           pocketed                        - sticky ball-sunk flag
module ball_cushion_friction
    import billiard_pkg::*;
#(
    parameter int TABLE_LEFT      = TABLE_LEFT_DEF,
    parameter int TABLE_RIGHT     = TABLE_RIGHT_DEF,
    parameter int TABLE_TOP       = TABLE_TOP_DEF,
    parameter int TABLE_BOTTOM    = TABLE_BOTTOM_DEF,
    parameter int BALL_SIZE       = BALL_SIZE_DEF,
    parameter int FRICTION_PERIOD = FRICTION_PERIOD_DEF,
    parameter int FRICTION_STEP   = FRICTION_STEP_DEF,
    parameter int POCKET_RADIUS   = POCKET_RADIUS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic signed [10:0] positionX,
    input  logic signed [10:0] positionY,
    input  logic signed [10:0] velocityX,
    input  logic signed [10:0] velocityY,
    output logic signed [10:0] outVelocityX,
    output logic signed [10:0] outVelocityY,
    output logic               velocityValid,
    output logic               ballMoving,
    output logic               pocketed
);

    localparam int FC_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRICTION_PERIOD - 1);

    localparam logic signed [11:0] LEFT_E    = 12'(TABLE_LEFT);
    localparam logic signed [11:0] RIGHT_E   = 12'(TABLE_RIGHT);
    localparam logic signed [11:0] TOP_E     = 12'(TABLE_TOP);
    localparam logic signed [11:0] BOTTOM_E  = 12'(TABLE_BOTTOM);
    localparam logic signed [11:0] EDGE_OFS  = 12'(BALL_SIZE - 1);
    localparam logic signed [11:0] HALF_BALL = 12'(BALL_SIZE / 2);

    localparam vel_t STEP     = 11'(FRICTION_STEP);
    localparam vel_t NEG_STEP = -STEP;

    // Moves v toward zero by STEP; anything within STEP of zero lands on zero.
    function automatic vel_t decay(input vel_t v);
        if (v > STEP) begin
            return v - STEP;
        end else if (v < NEG_STEP) begin
            return v + STEP;
        end
        return '0;
    endfunction

    state_e            state_q, state_d;
    logic signed [10:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    vel_t              vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    vel_t              out_vx_q, out_vx_d, out_vy_q, out_vy_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              valid_q, valid_d;
    logic              moving_q, moving_d;
    logic              pocketed_q, pocketed_d;

    // Edge and centre sums are 12-bit so a position near +1023 cannot wrap.
    logic signed [11:0] left_x, right_x, top_y, bottom_y, centre_x, centre_y;
    logic               reflect_x, reflect_y, pocket_hit;

    always_comb begin
        left_x    = {pos_x_q[10], pos_x_q};
        top_y     = {pos_y_q[10], pos_y_q};
        right_x   = left_x + EDGE_OFS;
        bottom_y  = top_y + EDGE_OFS;
        centre_x  = left_x + HALF_BALL;
        centre_y  = top_y + HALF_BALL;
        reflect_x = ((left_x <= LEFT_E) && (vel_x_q < 0)) ||
                    ((right_x >= RIGHT_E) && (vel_x_q > 0));
        reflect_y = ((top_y <= TOP_E) && (vel_y_q < 0)) ||
                    ((bottom_y >= BOTTOM_E) && (vel_y_q > 0));
    end

    ball_pocket_detect #(
        .POCKET_RADIUS (POCKET_RADIUS),
        .X_LEFT        (TABLE_LEFT),
        .X_MID         ((TABLE_LEFT + TABLE_RIGHT) / 2),
        .X_RIGHT       (TABLE_RIGHT),
        .Y_TOP         (TABLE_TOP),
        .Y_BOTTOM      (TABLE_BOTTOM)
    ) u_pocket (
        .centre_x (centre_x),
        .centre_y (centre_y),
        .hit      (pocket_hit)
    );

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        vel_x_d     = vel_x_q;
        vel_y_d     = vel_y_q;
        out_vx_d    = out_vx_q;
        out_vy_d    = out_vy_q;
        frame_cnt_d = frame_cnt_q;
        valid_d     = 1'b0;
        moving_d    = moving_q;
        pocketed_d  = pocketed_q;

        unique case (state_q)
            ST_IDLE: begin
                if (startOfFrame) begin
                    pos_x_d = positionX;
                    pos_y_d = positionY;
                    vel_x_d = velocityX;
                    vel_y_d = velocityY;
                    state_d = ST_CUSHION;
                end
            end
            ST_CUSHION: begin
                if (pocket_hit) begin
                    out_vx_d   = '0;
                    out_vy_d   = '0;
                    moving_d   = 1'b0;
                    pocketed_d = 1'b1;
                    state_d    = ST_SUNK;
                end else begin
                    if (reflect_x) vel_x_d = sat_neg(vel_x_q);
                    if (reflect_y) vel_y_d = sat_neg(vel_y_q);
                    state_d = ST_FRICTION;
                end
            end
            ST_FRICTION: begin
                if (frame_cnt_q == FC_LAST) begin
                    frame_cnt_d = '0;
                    vel_x_d     = decay(vel_x_q);
                    vel_y_d     = decay(vel_y_q);
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                out_vx_d = vel_x_q;
                out_vy_d = vel_y_q;
                moving_d = (vel_x_q != 0) || (vel_y_q != 0);
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_SUNK: begin
                state_d = ST_SUNK;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            vel_x_q     <= '0;
            vel_y_q     <= '0;
            out_vx_q    <= '0;
            out_vy_q    <= '0;
            frame_cnt_q <= '0;
            valid_q     <= 1'b0;
            moving_q    <= 1'b0;
            pocketed_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            vel_x_q     <= vel_x_d;
            vel_y_q     <= vel_y_d;
            out_vx_q    <= out_vx_d;
            out_vy_q    <= out_vy_d;
            frame_cnt_q <= frame_cnt_d;
            valid_q     <= valid_d;
            moving_q    <= moving_d;
            pocketed_q  <= pocketed_d;
        end
    end

    assign outVelocityX  = out_vx_q;
    assign outVelocityY  = out_vy_q;
    assign velocityValid = valid_q;
    assign ballMoving    = moving_q;
    assign pocketed      = pocketed_q;

endmodule

// File: tb/tb_ball_cushion_friction.sv
// tb/tb_ball_cushion_friction.sv - self-checking bench for ball_cushion_friction
module tb_ball_cushion_friction;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sof = 1'b0;
    logic signed [10:0] pos_x = '0, pos_y = '0, vel_x = '0, vel_y = '0;

    logic signed [10:0] ovx, ovy, r0_ovx, r0_ovy;
    logic vld, mov, pk, r0_vld, r0_mov, r0_pk;

    int errors = 0;
    int checks = 0;
    int m_fc = 0;

    always #5 clk = ~clk;

    ball_cushion_friction dut (
        .clk (clk), .reset (reset), .startOfFrame (sof),
        .positionX (pos_x), .positionY (pos_y),
        .velocityX (vel_x), .velocityY (vel_y),
        .outVelocityX (ovx), .outVelocityY (ovy),
        .velocityValid (vld), .ballMoving (mov), .pocketed (pk)
    );

    ball_cushion_friction #(.POCKET_RADIUS(0)) dut_r0 (
        .clk (clk), .reset (reset), .startOfFrame (sof),
        .positionX (pos_x), .positionY (pos_y),
        .velocityX (vel_x), .velocityY (vel_y),
        .outVelocityX (r0_ovx), .outVelocityY (r0_ovy),
        .velocityValid (r0_vld), .ballMoving (r0_mov), .pocketed (r0_pk)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sof   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_fc  = 0;
    endtask

    // Pulses startOfFrame, returns at the negedge three cycles after the
    // sampling edge, reporting whether valid appeared too early and at n+3.
    task automatic run_frame(input int px, input int py, input int vx, input int vy,
                             output logic early, output logic at3);
        @(negedge clk);
        pos_x = 11'(px);
        pos_y = 11'(py);
        vel_x = 11'(vx);
        vel_y = 11'(vy);
        sof   = 1'b1;
        @(negedge clk);
        sof   = 1'b0;
        @(negedge clk);
        early = vld;
        @(negedge clk);
        early = early | vld;
        @(negedge clk);
        at3 = vld;
    endtask

    // Reference model from the table rules, plain integer arithmetic.
    task automatic model_frame(input int px, input int py, input int vx, input int vy,
                               output int ox, output int oy, output bit sunk);
        int cx, cy, r;
        int pxs[3];
        int pys[2];
        pxs[0] = 32; pxs[1] = (32 + 607) / 2; pxs[2] = 607;
        pys[0] = 32; pys[1] = 447;
        r  = 12;
        cx = px + 8;
        cy = py + 8;
        sunk = 1'b0;
        foreach (pxs[i]) foreach (pys[j])
            if (cx >= pxs[i] - r && cx <= pxs[i] + r && cy >= pys[j] - r && cy <= pys[j] + r)
                sunk = 1'b1;
        ox = vx;
        oy = vy;
        if (sunk) begin
            ox = 0;
            oy = 0;
            return;
        end
        if ((px <= 32 && vx < 0) || (px + 15 >= 607 && vx > 0)) ox = (-vx > 1023) ? 1023 : -vx;
        if ((py <= 32 && vy < 0) || (py + 15 >= 447 && vy > 0)) oy = (-vy > 1023) ? 1023 : -vy;
        if (m_fc == 3) begin
            m_fc = 0;
            ox = (ox > 1) ? ox - 1 : (ox < -1) ? ox + 1 : 0;
            oy = (oy > 1) ? oy - 1 : (oy < -1) ? oy + 1 : 0;
        end else begin
            m_fc++;
        end
    endtask

    initial begin
        logic early, at3;
        int ex, ey, px, py, vx, vy;
        bit sunk;

        do_reset();
        check("reset_ovx", ovx, 0);
        check("reset_ovy", ovy, 0);
        check("reset_vld", vld, 0);
        check("reset_mov", mov, 0);
        check("reset_pk", pk, 0);

        // Left-cushion reflection.
        run_frame(30, 200, -5, 3, early, at3);
        check("t1_early", early, 0);
        check("t1_valid", at3, 1);
        check("t1_ovx", ovx, 5);
        check("t1_ovy", ovy, 3);
        check("t1_mov", mov, 1);
        @(negedge clk);
        check("t1_pulse_one_cycle", vld, 0);
        check("t1_hold_ovx", ovx, 5);

        // Friction cadence: fourth frame decays.
        do_reset();
        for (int f = 1; f <= 4; f++) begin
            run_frame(300, 200, 3, -1, early, at3);
            check($sformatf("t2_valid_f%0d", f), at3, 1);
            check($sformatf("t2_ovx_f%0d", f), ovx, (f == 4) ? 2 : 3);
            check($sformatf("t2_ovy_f%0d", f), ovy, (f == 4) ? 0 : -1);
        end
        check("t2_mov", mov, 1);

        // Saturating negation in a corner.
        do_reset();
        run_frame(0, 0, -1024, -7, early, at3);
        check("t3_valid", at3, 1);
        check("t3_ovx", ovx, 1023);
        check("t3_ovy", ovy, 7);
        check("t3_r0_valid", r0_vld, 1);
        check("t3_r0_ovx", r0_ovx, 1023);
        check("t3_r0_ovy", r0_ovy, 7);
        check("t3_r0_pk", r0_pk, 0);

        // Pocketing; subsequent frames are ignored.
        do_reset();
        run_frame(300, 200, 3, 3, early, at3);
        run_frame(24, 24, 4, 4, early, at3);
        check("t4_valid", early | at3, 0);
        check("t4_pk", pk, 1);
        check("t4_ovx", ovx, 0);
        check("t4_ovy", ovy, 0);
        check("t4_mov", mov, 0);
        check("t4_r0_pk", r0_pk, 1);
        for (int f = 0; f < 3; f++) begin
            run_frame(300, 200, 3, 3, early, at3);
            check($sformatf("t4_ignored_%0d", f), early | at3, 0);
        end
        check("t4_pk_sticky", pk, 1);

        // Reset from SUNK, then a normal frame.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_fc  = 0;
        check("t5_rst_pk", pk, 0);
        check("t5_rst_ovx", ovx, 0);
        check("t5_rst_mov", mov, 0);
        run_frame(300, 200, 3, -1, early, at3);
        check("t5_after_valid", at3, 1);
        check("t5_after_ovx", ovx, 3);
        check("t5_after_ovy", ovy, -1);

        // Back-to-back startOfFrame: the second is dropped.
        do_reset();
        @(negedge clk);
        pos_x = 11'(300); pos_y = 11'(200); vel_x = 11'(2); vel_y = 11'(2);
        sof = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sof = 1'b0;
        begin
            int nvalid = 0;
            logic seen3;
            for (int c = 1; c <= 6; c++) begin
                if (c == 3) seen3 = vld;
                if (vld) nvalid++;
                @(negedge clk);
            end
            check("t5_busy_at_n3", seen3, 1);
            check("t5_busy_count", nvalid, 1);
        end

        // Randomized frames against the model.
        do_reset();
        for (int k = 0; k < 60; k++) begin
            px = int'($urandom_range(0, 640));
            py = int'($urandom_range(0, 470));
            if ($urandom_range(0, 9) == 0) px = int'($urandom_range(0, 2047)) - 1024;
            vx = int'($urandom_range(0, 40)) - 20;
            vy = int'($urandom_range(0, 40)) - 20;
            if ($urandom_range(0, 7) == 0) vx = int'($urandom_range(0, 2047)) - 1024;
            if ($urandom_range(0, 7) == 0) vy = -1024;
            model_frame(px, py, vx, vy, ex, ey, sunk);
            run_frame(px, py, vx, vy, early, at3);
            check($sformatf("rnd%0d_early", k), early, 0);
            check($sformatf("rnd%0d_valid", k), at3, sunk ? 0 : 1);
            check($sformatf("rnd%0d_pk", k), pk, sunk ? 1 : 0);
            check($sformatf("rnd%0d_ovx", k), ovx, ex);
            check($sformatf("rnd%0d_ovy", k), ovy, ey);
            check($sformatf("rnd%0d_mov", k), mov, (ex != 0 || ey != 0) ? 1 : 0);
            if (sunk) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_cushion_friction.md
Name: ball_cushion_friction

Overview:
- Downstream neighbour of the ball position/velocity integrator.
- Once per video frame it consumes the ball's current position and velocity.
- It reflects the velocity off the table cushions, applies periodic friction decay and detects pocketing.
- It produces the next-frame velocity, which is fed back to the integrator's velocity inputs.

Parameters:
- TABLE_LEFT, 32: leftmost playable pixel X.
- TABLE_RIGHT, 607: rightmost playable pixel X.
- TABLE_TOP, 32: topmost playable pixel Y.
- TABLE_BOTTOM, 447: bottom playable pixel Y.
- BALL_SIZE, 16: ball bounding-box side in pixels. Ball centre = position + BALL_SIZE/2.
- FRICTION_PERIOD, 4: friction is applied once every this many processed frames (must be ≥1).
- FRICTION_STEP, 1: magnitude removed from each velocity component per friction event.
- POCKET_RADIUS, 12: half-side of the square capture window around each pocket centre.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse, once per frame.
- positionX  in  11 signed  ball top-left X.
- positionY  in  11 signed  ball top-left Y.
- velocityX  in  11 signed  current velocity X.
- velocityY  in  11 signed  current velocity Y.
- outVelocityX  out  11 signed  next-frame velocity X.
- outVelocityY  out  11 signed  next-frame velocity Y.
- velocityValid  out  1  one-cycle pulse; out velocities updated this cycle.
- ballMoving  out  1  high when either out velocity is nonzero.
- pocketed  out  1  sticky, high once the ball is sunk.

Behaviour:
- Reset:
  - All outputs 0, FSM in IDLE, frame counter 0, internal captured registers 0.
  - Reset wins over every other event, including mid-operation and in SUNK.
- FSM states: IDLE, CUSHION, FRICTION, OUTPUT, SUNK.
- IDLE:
  - On startOfFrame, register all four inputs and go to CUSHION.
  - startOfFrame in any state other than IDLE is ignored; no queueing.
- CUSHION (one cycle):
  - Pocket check first. The ball centre lies within ±POCKET_RADIUS (inclusive) in both axes of any of the 6 pocket centres: (TABLE_LEFT,TABLE_TOP), ((TABLE_LEFT+TABLE_RIGHT)/2,TABLE_TOP), (TABLE_RIGHT,TABLE_TOP), and the same three X values at TABLE_BOTTOM.
  - On a pocket hit: go to SUNK. Pocket takes priority over any reflection.
  - X reflection: if positionX <= TABLE_LEFT and vx < 0, or positionX+BALL_SIZE-1 >= TABLE_RIGHT and vx > 0, then vx = -vx.
  - Y reflection: same rule against TABLE_TOP and TABLE_BOTTOM.
  - Both axes may reflect in the same frame (corner).
  - Negation saturates: -(-1024) = +1023.
  - Velocity of 0 is never reflected.
  - Go to FRICTION.
- FRICTION (one cycle):
  - If frame counter == FRICTION_PERIOD-1: counter wraps to 0, and each nonzero component moves toward 0 by FRICTION_STEP, clamped at 0 (the sign never flips).
  - Otherwise: counter increments and velocities are unchanged.
  - Only frames that reach FRICTION advance the counter.
  - Go to OUTPUT.
- OUTPUT (one cycle):
  - Load outVelocityX/Y and set velocityValid = 1 for this cycle only.
  - ballMoving updates together with the out velocities.
  - Go to IDLE.
- Latency: startOfFrame sampled in cycle n → velocityValid and new outputs in cycle n+3. Outputs hold between updates.
- SUNK:
  - On entry, outVelocityX/Y = 0, ballMoving = 0, pocketed = 1.
  - Terminal state; only reset exits. velocityValid never pulses in SUNK.
- Width rule: all arithmetic is 11-bit signed. Edge sums (position+BALL_SIZE-1) are computed 12-bit to avoid overflow.

Decomposition:
- Shared package billiard_pkg holds:
  - the FSM state enum;
  - the table bound and ball size defaults;
  - the 6 pocket-centre constants;
  - a velocity typedef (logic signed [10:0]).
- One natural sub-module: ball_pocket_detect. It is combinational and takes the ball centre X/Y, outputs a hit flag, and compares against the 6 pockets from the package.

Test Plan:
1. Left-cushion reflection: after reset, pulse startOfFrame with pos (30,200), vel (-5,3) → 3 cycles later velocityValid=1, out (5,3), ballMoving=1.
2. Friction cadence: 4 consecutive frames with pos (300,200), vel (3,-1) → frames 1–3 out (3,-1); frame 4 out (2,0).
3. Saturation and corner: pos (0,0) outside the pocket window via an override of POCKET_RADIUS=0, vel (-1024,-7) → out (1023,7); both axes reflected.
4. Pocket: pos (24,24), meaning centre (32,32), vel (4,4) → pocketed=1, out (0,0), ballMoving=0; 3 further startOfFrame pulses produce no velocityValid.
5. Busy/ignore and reset: pulse startOfFrame in cycles n and n+1 → exactly one velocityValid at n+3. Assert reset while in SUNK → next cycle pocketed=0 and outputs 0, and a subsequent frame processes normally.
